// File: rtl/delayed_io_seq_ctrl_if.sv
// Bus bundle for delayed_io_seq_ctrl: step-table config port, sequence
// control, pin outputs and a debug view of the sequencer state.
//   master : drives config/control inputs, observes outputs (register block)
//   slave  : the sequencer itself
// Optional input i_loop exists only when DELAYED_IO_SEQ_LOOP_EN is defined.
interface delayed_io_seq_ctrl_if #(
  parameter int NUM_OUTPUTS = 4,
  parameter int NUM_STEPS   = 8,
  parameter int CNT_W       = 32
);
  localparam int IDX_W = $clog2(NUM_STEPS);

  logic                   i_cfg_we;
  logic [IDX_W-1:0]       i_cfg_addr;
  logic [CNT_W-1:0]       i_cfg_delay;
  logic [NUM_OUTPUTS-1:0] i_cfg_mask;
  logic [NUM_OUTPUTS-1:0] i_cfg_val;
  logic [IDX_W:0]         i_num_steps;
  logic                   i_trigger;
  logic                   i_abort;
  logic [NUM_OUTPUTS-1:0] i_idle_val;
`ifdef DELAYED_IO_SEQ_LOOP_EN
  logic                   i_loop;
`endif
  logic [NUM_OUTPUTS-1:0] o_io_pins;
  logic                   o_busy;
  logic                   o_done;
  logic [IDX_W-1:0]       o_step_idx;
  logic                   o_cfg_err;
  logic [1:0]             dbg_state;

  modport master (
`ifdef DELAYED_IO_SEQ_LOOP_EN
    output i_loop,
`endif
    output i_cfg_we, i_cfg_addr, i_cfg_delay, i_cfg_mask, i_cfg_val,
    output i_num_steps, i_trigger, i_abort, i_idle_val,
    input  o_io_pins, o_busy, o_done, o_step_idx, o_cfg_err, dbg_state
  );

  modport slave (
`ifdef DELAYED_IO_SEQ_LOOP_EN
    input  i_loop,
`endif
    input  i_cfg_we, i_cfg_addr, i_cfg_delay, i_cfg_mask, i_cfg_val,
    input  i_num_steps, i_trigger, i_abort, i_idle_val,
    output o_io_pins, o_busy, o_done, o_step_idx, o_cfg_err, dbg_state
  );
endinterface

// File: rtl/delayed_io_seq_ctrl.sv
// delayed_io_seq_ctrl: walks a programmable step table on a trigger edge.
// Each step waits its delay (shared down-counter) and then applies its
// masked pin values. Abort (level) forces i_idle_val onto the pins.
// Ports:
//   clk, rst_n (async, active-low)
//   bus (delayed_io_seq_ctrl_if.slave):
//     i_cfg_we/addr/delay/mask/val : step table write port
//     i_num_steps : active steps, clamped to NUM_STEPS, sampled at trigger
//     i_trigger   : start on rising edge; i_abort / i_idle_val : cancel
//     o_io_pins, o_busy, o_done, o_step_idx, o_cfg_err, dbg_state (FSM state)
// Optional: define DELAYED_IO_SEQ_LOOP_EN to add i_loop (repeat passes).
//
// Config strobe contract: i_cfg_we is a single-cycle write strobe with no
// ready. It is accepted on the sampling edge when the FSM is IDLE or DONE;
// otherwise it is dropped and o_cfg_err pulses for the following cycle.
module delayed_io_seq_ctrl #(
  parameter int NUM_OUTPUTS = 4,
  parameter int NUM_STEPS   = 8,
  parameter int CNT_W       = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  delayed_io_seq_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_STEPS);
  localparam int NS_W  = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [NUM_OUTPUTS-1:0] pins_q, pins_d;
  logic                   done_q, done_d;
  logic                   trig_prev_q;
  logic                   cfg_err_q;

  logic [CNT_W-1:0]       delay_q [NUM_STEPS];
  logic [NUM_OUTPUTS-1:0] mask_q  [NUM_STEPS];
  logic [NUM_OUTPUTS-1:0] val_q   [NUM_STEPS];

  logic                   trig_edge;
  logic                   cfg_ok;
  logic [NS_W-1:0]        ns_clamped;
  logic [IDX_W-1:0]       idx_inc;

  assign trig_edge  = bus.i_trigger & ~trig_prev_q;
  assign cfg_ok     = (state_q != RUN);
  assign ns_clamped = (bus.i_num_steps > NS_W'(NUM_STEPS)) ? NS_W'(NUM_STEPS)
                                                           : bus.i_num_steps;
  assign idx_inc    = idx_q + IDX_W'(1);

  // Step table, trigger history and config-error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        delay_q[i] <= '0;
        mask_q[i]  <= '0;
        val_q[i]   <= '0;
      end
      trig_prev_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      trig_prev_q <= bus.i_trigger;
      cfg_err_q   <= bus.i_cfg_we & ~cfg_ok;
      if (bus.i_cfg_we && cfg_ok) begin
        delay_q[bus.i_cfg_addr] <= bus.i_cfg_delay;
        mask_q[bus.i_cfg_addr]  <= bus.i_cfg_mask;
        val_q[bus.i_cfg_addr]   <= bus.i_cfg_val;
      end
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      pins_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      pins_q  <= pins_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    pins_d  = pins_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (trig_edge) begin
          if (ns_clamped == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = delay_q[0];
            idx_d   = '0;
            // Last index is latched so later i_num_steps changes are ignored.
            last_d  = IDX_W'(ns_clamped - NS_W'(1));
          end
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          pins_d = (pins_q & ~mask_q[idx_q]) | (val_q[idx_q] & mask_q[idx_q]);
          if (idx_q == last_q) begin
            done_d  = 1'b1;
            state_d = DONE;
`ifdef DELAYED_IO_SEQ_LOOP_EN
            if (bus.i_loop) begin
              state_d = RUN;
              idx_d   = '0;
              cnt_d   = delay_q[0];
            end
`endif
          end else begin
            idx_d = idx_inc;
            cnt_d = delay_q[idx_inc];
          end
        end
      end
      DONE: begin
        // idx is held here so software can read the final step index.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything, including a coincident trigger edge.
    if (bus.i_abort) begin
      state_d = IDLE;
      pins_d  = bus.i_idle_val;
      cnt_d   = '0;
      idx_d   = '0;
      done_d  = 1'b0;
    end
  end

  assign bus.o_io_pins  = pins_q;
  assign bus.o_busy     = (state_q == RUN);
  assign bus.o_done     = done_q;
  assign bus.o_step_idx = idx_q;
  assign bus.o_cfg_err  = cfg_err_q;
  assign bus.dbg_state  = state_q;
endmodule

// File: doc/delayed_io_seq_ctrl.md
Name: delayed_io_seq_ctrl

Overview:
Programmable sequencer that drives a bank of delayed IO pins through up to NUM_STEPS timed steps from one shared down-counter. A small step table is loaded through a config write port. On a trigger edge the block walks the table: it waits each step's delay, then applies that step's masked pin values. It sits between the register block and the board IO pins, replacing per-pin single-delay FSMs for multi-edge sequences such as sensor power-up or reset ordering.

Parameters:
NUM_OUTPUTS, 4, number of IO pins driven
NUM_STEPS, 8, depth of the step table (power of 2, >=2)
CNT_W, 32, width of per-step delay field and counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
i_cfg_we  in  1  step table write strobe
i_cfg_addr  in  $clog2(NUM_STEPS)  step index to write
i_cfg_delay  in  CNT_W  delay for step, in clk cycles
i_cfg_mask  in  NUM_OUTPUTS  pins affected by step
i_cfg_val  in  NUM_OUTPUTS  values applied to masked pins
i_num_steps  in  $clog2(NUM_STEPS)+1  active steps; values above NUM_STEPS are clamped to NUM_STEPS
i_trigger  in  1  start; rising edge only
i_abort  in  1  level; cancel sequence
i_idle_val  in  NUM_OUTPUTS  pin values forced on abort
o_io_pins  out  NUM_OUTPUTS  registered pin outputs
o_busy  out  1  sequence running
o_done  out  1  1-cycle pulse at sequence completion
o_step_idx  out  $clog2(NUM_STEPS)  current step index
o_cfg_err  out  1  1-cycle pulse: write rejected while busy

Behaviour:
- Reset values: o_io_pins=0, o_busy=0, o_done=0, o_step_idx=0, o_cfg_err=0, state=IDLE, counter=0, table contents=0.
- Trigger edge: registered i_trigger_prev; edge = i_trigger & ~prev. Edge detection runs in all states.
- States: IDLE, RUN, DONE.
- IDLE:
  - Edge with clamped num_steps=0 -> DONE; pins unchanged.
  - Edge with num_steps>0 -> RUN; counter<=delay[0]; idx<=0.
- RUN:
  - counter!=0: counter<=counter-1.
  - counter==0: pins <= (pins & ~mask[idx]) | (val[idx] & mask[idx]).
  - Then, if idx==num_steps-1 -> DONE; else idx<=idx+1 and counter<=delay[idx+1].
  - Timing: step 0 applies delay[0]+1 edges after the trigger-sampling edge. Step k applies delay[k]+1 edges after step k-1. delay=0 means apply on the next edge.
- DONE: o_done=1 for exactly one cycle, then IDLE. idx is held until the next trigger.
- o_busy=1 in RUN only (combinational from state).
- num_steps is sampled at the trigger edge; changes mid-run are ignored.
- Trigger edges in RUN or DONE are ignored; no queuing.
- Abort: highest priority. In any state, the next edge gives IDLE, pins<=i_idle_val, counter<=0, idx<=0, no o_done. Abort coincident with a trigger edge: abort wins, sequence not started.
- Config writes:
  - Accepted only in IDLE and DONE; visible to a trigger one cycle later.
  - A write while in RUN is dropped and o_cfg_err pulses the next cycle.
- Counter arithmetic: unsigned CNT_W; never decrements below 0.
- Async reset mid-sequence: all outputs return to reset values immediately.

Optional Feature:
- Macro: DELAYED_IO_SEQ_LOOP_EN.
- Enabled:
  - Adds input i_loop (1 bit).
  - If i_loop=1 when the last step applies, idx<=0 and counter<=delay[0]; state stays RUN and o_done pulses once per pass while o_busy stays 1.
  - i_loop=0 at the last step gives normal DONE. Exit otherwise only by abort.
- Disabled: no i_loop port; always single-shot.

Test Plan:
- Table {0: d=3,m=0001,v=0001; 1: d=0,m=0011,v=0010}, num_steps=2, trigger at edge 0 -> pins=0001 at edge 4, pins=0010 at edge 5, o_done high cycle 6, o_busy high cycles 1-5.
- num_steps=0, trigger -> o_done pulse next cycle, o_busy never high, pins unchanged.
- Abort with idle_val=1010 while in step 1 of a 3-step run -> pins=1010 next edge, no o_done, idx=0, then a new trigger restarts from step 0.
- Config write during RUN -> o_cfg_err 1-cycle pulse, table readback via a subsequent run shows the old value; write in IDLE is accepted.
- Trigger held high through completion plus second edge during RUN -> only one sequence runs; i_num_steps=15 with NUM_STEPS=8 -> exactly 8 steps applied.
- LOOP_EN, i_loop=1, 2 steps with d=1 each -> o_done pulses every 4 cycles with o_busy=1; deassert i_loop -> DONE after the current pass.
